// File: rtl/qrisc32_ex_seq.sv
// Iterative EX-stage sequencer for MUL/SHL/SHR: shift-add multiplier and one-bit-per-cycle
// shifter that stalls the pipeline until the 32-bit result and Z/C flags are ready.
module qrisc32_ex_seq #(
  parameter int STEP_BITS = 1  // 1, 2 or 4 multiplier bits per RUN cycle
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        flush,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] result,
  output logic        flag_c,
  output logic        flag_z
);

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_SHL = 2'b01;
  localparam logic [1:0] OP_SHR = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;
  localparam logic [5:0] MUL_N  = 6'(32 / STEP_BITS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_result;
  logic        r_c;
  logic        r_z;
  logic [5:0]  r_cnt;
  logic [1:0]  r_op;
  logic [32:0] r_acc;
  logic [32:0] r_mcand;
  logic [31:0] r_mplr;

  logic        w_accept;
  logic [5:0]  w_shift_n;
  logic [5:0]  w_n;
  logic [32:0] w_pp;
  logic [32:0] w_acc_next;
  logic [31:0] w_fin_res;
  logic        w_fin_c;

  assign w_accept  = start & ~flush & (r_state == S_IDLE);
  assign stall_req = w_accept | (r_state == S_RUN);

  // Any shift of 33 or more clears every bit of the 33-bit window, so 33 iterations suffice.
  assign w_shift_n = ((|opb[31:6]) || (opb[5:0] > 6'd33)) ? 6'd33 : opb[5:0];
  assign w_n       = (op == OP_MUL) ? MUL_N : w_shift_n;

  // Only the low 33 product bits are kept, so the accumulator wraps at 33 bits.
  assign w_pp = r_mcand * {{(33 - STEP_BITS){1'b0}}, r_mplr[STEP_BITS-1:0]};

  always_comb begin
    w_acc_next = r_acc;
    case (r_op)
      OP_MUL:  w_acc_next = r_acc + w_pp;
      OP_SHL:  w_acc_next = {r_acc[31:0], 1'b0};
      OP_SHR:  w_acc_next = {1'b0, r_acc[32:1]};
      default: w_acc_next = r_acc;
    endcase
  end

  // SHR keeps the carry below the result; MUL and SHL keep it above.
  assign w_fin_res = (r_op == OP_SHR) ? r_acc[32:1] : r_acc[31:0];
  assign w_fin_c   = (r_op == OP_SHR) ? r_acc[0]    : r_acc[32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_c      <= 1'b0;
      r_z      <= 1'b0;
      r_cnt    <= '0;
      r_op     <= OP_MUL;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplr   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= op;
            r_busy <= 1'b1;
            if (op == OP_NOP) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= '0;
              r_c      <= 1'b0;
              r_z      <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_cnt   <= w_n;
              r_mcand <= {1'b0, opa};
              r_mplr  <= opb;
              case (op)
                OP_SHL:  r_acc <= {1'b0, opa};
                OP_SHR:  r_acc <= {opa, 1'b0};
                default: r_acc <= '0;
              endcase
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt != 6'd0) begin
            r_cnt   <= r_cnt - 6'd1;
            r_acc   <= w_acc_next;
            r_mcand <= r_mcand << STEP_BITS;
            r_mplr  <= r_mplr >> STEP_BITS;
          end else begin
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_result <= w_fin_res;
            r_c      <= w_fin_c;
            r_z      <= (w_fin_res == 32'd0);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign flag_c = r_c;
  assign flag_z = r_z;

endmodule

// File: tb/tb_qrisc32_ex_seq.sv
// Scoreboard bench for qrisc32_ex_seq: one instance with STEP_BITS=1, one with STEP_BITS=4,
// sharing operands/flush/reset but with separate start lines.
module tb_qrisc32_ex_seq;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        z;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  start_v = 2'b00;
  logic [1:0]  op = 2'b00;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        flush = 1'b0;
  logic [1:0]  busy, stall_req, done, flag_c, flag_z;
  logic [31:0] result [2];

  exp_t        sb [$];
  logic [31:0] last_res [2];
  logic        last_c [2];
  logic        last_z [2];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  qrisc32_ex_seq #(.STEP_BITS(1)) u_dut_s1 (
    .clk(clk), .reset(reset), .start(start_v[0]), .op(op), .opa(opa), .opb(opb),
    .flush(flush), .busy(busy[0]), .stall_req(stall_req[0]), .done(done[0]),
    .result(result[0]), .flag_c(flag_c[0]), .flag_z(flag_z[0])
  );

  qrisc32_ex_seq #(.STEP_BITS(4)) u_dut_s4 (
    .clk(clk), .reset(reset), .start(start_v[1]), .op(op), .opa(opa), .opb(opb),
    .flush(flush), .busy(busy[1]), .stall_req(stall_req[1]), .done(done[1]),
    .result(result[1]), .flag_c(flag_c[1]), .flag_z(flag_z[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int sel, input logic [1:0] o,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    logic [32:0] t;
    int          n;
    e = '0;
    case (o)
      2'b00: begin
        p = 64'(a) * 64'(b);
        e.res = p[31:0];
        e.c = p[32];
        n = (sel == 1) ? 8 : 32;
      end
      2'b01: begin
        t = {1'b0, a};
        t = (b >= 33) ? 33'd0 : (t << b);
        e.res = t[31:0];
        e.c = t[32];
        n = (b >= 33) ? 33 : int'(b);
      end
      2'b10: begin
        t = {a, 1'b0};
        t = (b >= 33) ? 33'd0 : (t >> b);
        e.res = t[32:1];
        e.c = t[0];
        n = (b >= 33) ? 33 : int'(b);
      end
      default: begin
        e.res = '0;
        e.c = 1'b0;
        n = -1;
      end
    endcase
    e.z = (e.res == 32'd0);
    e.cyc = n + 2;
    return e;
  endfunction

  // flush_at / start_at < 0 disable the flush pulse / the extra start during RUN.
  task automatic do_op(input int sel, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int flush_at, input int start_at);
    exp_t e, got;
    bit   seen;
    seen = 1'b0;
    e = model(sel, o, a, b);
    @(posedge clk); #1;
    start_v[sel] = 1'b1;
    op = o; opa = a; opb = b;
    if (flush_at < 0) sb.push_back(e);
    @(negedge clk);
    check("stall_cycle0", 32'(stall_req[sel]), 32'd1);
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk); #1;
      start_v[sel] = 1'b0;
      op = 2'($urandom_range(3));
      opa = $urandom;
      opb = $urandom;
      flush = (c == flush_at);
      if (c == start_at) begin
        start_v[sel] = 1'b1;
        op = 2'b01;
        opb = 32'd0;
      end
      @(negedge clk);
      if (flush_at >= 0) begin
        if (c <= flush_at) begin
          check("no_done_before_flush", 32'(done[sel]), 32'd0);
        end else begin
          check("flush_stall", 32'(stall_req[sel]), 32'd0);
          check("flush_busy", 32'(busy[sel]), 32'd0);
          check("flush_done", 32'(done[sel]), 32'd0);
          check("flush_result_kept", result[sel], last_res[sel]);
          check("flush_c_kept", 32'(flag_c[sel]), 32'(last_c[sel]));
          check("flush_z_kept", 32'(flag_z[sel]), 32'(last_z[sel]));
          if (c >= flush_at + 3) break;
        end
      end else if (done[sel]) begin
        if (sb.size() == 0) begin
          check("scoreboard_empty", 32'(done[sel]), 32'd0);
        end else begin
          got = sb.pop_front();
          $display("op%0d dut%0d a=%08h b=%08h -> res=%08h c=%0b z=%0b at cycle %0d",
                   o, sel, a, b, result[sel], flag_c[sel], flag_z[sel], c);
          check("done_cycle", 32'(c), 32'(got.cyc));
          check("result", result[sel], got.res);
          check("flag_c", 32'(flag_c[sel]), 32'(got.c));
          check("flag_z", 32'(flag_z[sel]), 32'(got.z));
          check("stall_in_done", 32'(stall_req[sel]), 32'd0);
          last_res[sel] = got.res;
          last_c[sel] = got.c;
          last_z[sel] = got.z;
        end
        seen = 1'b1;
        break;
      end else begin
        if (c >= e.cyc) begin
          check("done_at_cycle", 32'(done[sel]), 32'd1);
          break;
        end
        check("stall_running", 32'(stall_req[sel]), 32'd1);
      end
    end
    if (flush_at < 0 && !seen && sb.size() > 0) void'(sb.pop_front());
    start_v = 2'b00;
    flush = 1'b0;
    @(negedge clk);
    check("idle_after_op_done", 32'(done[sel]), 32'd0);
    check("idle_after_op_busy", 32'(busy[sel]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      last_res[i] = '0;
      last_c[i] = 1'b0;
      last_z[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_busy", 32'(busy[i]), 32'd0);
      check("reset_done", 32'(done[i]), 32'd0);
      check("reset_result", result[i], 32'd0);
      check("reset_flags", {30'd0, flag_c[i], flag_z[i]}, 32'd0);
    end
    reset = 1'b1;

    do_op(0, 2'b00, 32'h0001_0000, 32'h0001_0000, -1, -1);
    do_op(1, 2'b00, 32'd7, 32'd6, -1, -1);
    do_op(1, 2'b11, 32'h1234_5678, 32'h9abc_def0, -1, -1);
    do_op(0, 2'b01, 32'h8000_0001, 32'd1, -1, -1);
    do_op(0, 2'b01, 32'h1234_5678, 32'd0, -1, -1);
    do_op(0, 2'b01, 32'hffff_ffff, 32'd40, -1, -1);
    do_op(0, 2'b01, 32'h0000_0001, 32'd32, -1, -1);
    do_op(0, 2'b01, 32'h0000_0003, 32'h0001_0002, -1, -1);
    do_op(0, 2'b10, 32'h0000_0003, 32'd1, -1, -1);
    do_op(0, 2'b10, 32'hffff_ffff, 32'd33, -1, -1);
    do_op(0, 2'b10, 32'h8000_0000, 32'd32, -1, -1);
    do_op(0, 2'b10, 32'hcafe_f00d, 32'd0, -1, -1);
    do_op(1, 2'b00, 32'hffff_ffff, 32'hffff_ffff, -1, -1);
    for (int k = 0; k < 3; k++) begin
      do_op(k % 2, 2'b00, $urandom, $urandom, -1, -1);
    end

    // Flush mid-MUL: outputs must keep the previous op's values.
    do_op(0, 2'b00, 32'd5, 32'd5, 10, -1);
    // Start pulsed during RUN must be ignored.
    do_op(0, 2'b00, 32'h0000_1234, 32'h0000_5678, -1, 5);

    // Start and flush together in IDLE: not accepted.
    @(posedge clk); #1;
    start_v[0] = 1'b1; flush = 1'b1; op = 2'b00; opa = 32'd5; opb = 32'd5;
    @(negedge clk);
    check("start_flush_stall", 32'(stall_req[0]), 32'd0);
    @(posedge clk); #1;
    start_v = 2'b00; flush = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("start_flush_busy", 32'(busy[0]), 32'd0);
      check("start_flush_done", 32'(done[0]), 32'd0);
    end

    // Asynchronous reset mid-RUN, between clock edges.
    @(posedge clk); #1;
    start_v[0] = 1'b1; op = 2'b00; opa = 32'hdead_beef; opb = 32'd7;
    @(posedge clk); #1;
    start_v = 2'b00;
    repeat (5) @(posedge clk);
    #3;
    check("pre_reset_busy", 32'(busy[0]), 32'd1);
    reset = 1'b0;
    #1;
    check("async_reset_busy", 32'(busy[0]), 32'd0);
    check("async_reset_stall", 32'(stall_req[0]), 32'd0);
    check("async_reset_result", result[0], 32'd0);
    check("async_reset_result_s4", result[1], 32'd0);
    check("async_reset_done", 32'(done[0]), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      last_res[i] = '0;
      last_c[i] = 1'b0;
      last_z[i] = 1'b0;
    end
    do_op(0, 2'b00, 32'd3, 32'd3, -1, -1);
    do_op(1, 2'b00, 32'd3, 32'd3, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/qrisc32_ex_seq.md
Name: qrisc32_ex_seq

Overview:
Multi-cycle sequencer for the EX-stage MUL, SHL and SHR operations. It replaces the single-cycle multiplier and barrel shifter with an iterative shift-add and shift datapath. While an operation is in flight it holds the pipeline through a stall request. It returns the 32-bit result plus the Z and C flags with the same arithmetic semantics as the single-cycle EX ops, so the EX stage can latch them unchanged.

Parameters:
STEP_BITS, 1, multiplier bits consumed per RUN cycle; legal values 1, 2, 4; MUL iterations = 32/STEP_BITS.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  request a new operation; sampled only in IDLE.
op  in  2  operation select: 00 MUL, 01 SHL, 10 SHR, 11 reserved.
opa  in  32  operand A (val_r1).
opb  in  32  operand B (val_r2): multiplier or shift amount.
flush  in  1  abort the current operation (branch taken or pipeline kill).
busy  out  1  high in RUN and DONE.
stall_req  out  1  combinational: (start & ~flush & state==IDLE) | state==RUN.
done  out  1  one-cycle pulse; result, flag_c and flag_z are valid this cycle.
result  out  32  operation result.
flag_c  out  1  carry flag.
flag_z  out  1  zero flag: result == 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE.
  - busy, done, result, flag_c, flag_z, iteration counter and internal accumulators all 0.
- States:
  - IDLE -> RUN on start & ~flush & op!=11. Operands are latched and the iteration count N is computed.
  - start with op=11 is accepted as a no-op: IDLE -> DONE, result=0, C=0, Z=1.
  - RUN: one iteration per cycle; counter decrements. Transition to DONE in the cycle after the last iteration.
  - N=0: RUN is held for exactly one cycle with no datapath change, then DONE.
  - DONE: done=1 for one cycle, then IDLE unconditionally.
- Latency:
  - start accepted in cycle 0; done=1 in cycle N+2 (N=0 gives cycle 2).
  - stall_req is high in cycles 0..N+1 and low in the DONE cycle, so the pipeline advances exactly when the result is valid.
- MUL:
  - Unsigned shift-add, STEP_BITS multiplier bits per cycle; N = 32/STEP_BITS (32 for the default).
  - 64-bit product P: result = P[31:0], flag_c = P[32]. Bits above 32 are discarded, i.e. {C,dst} = truncation of opa*opb to 33 bits.
- SHL:
  - {flag_c,result} = {1'b0,opa} << opb, one bit per cycle.
  - N = min(opb,33); any opb >= 33 (upper bits included) gives result=0, C=0.
- SHR:
  - {result,flag_c} = {opa,1'b0} >> opb, one bit per cycle.
  - N = min(opb,33); opb=0 gives result=opa, C=0.
- Outputs:
  - result, flag_c and flag_z are registered.
  - They hold their DONE-cycle values through IDLE until the next DONE.
  - They are not updated on flush or abort.
- Start handling:
  - start while busy is ignored; no queueing.
  - start and flush in the same IDLE cycle: flush wins, the request is not accepted and stall_req=0.
- Flush:
  - flush in RUN: state goes to IDLE next cycle, no done pulse, outputs unchanged, stall_req drops in the next cycle.
  - flush in DONE: no effect; done still pulses and the EX stage discards the result.
- Reset during RUN: immediate abort to the reset values; no done pulse.
- Operands: opa, opb and op are ignored after the accept cycle and may change freely.

Test Plan:
- MUL 0x0001_0000 * 0x0001_0000, STEP_BITS=1 -> done at cycle 34; result=0, C=1, Z=1; stall_req high cycles 0..33.
- MUL 7*6 with STEP_BITS=4 -> done at cycle 10, result=42, C=0, Z=0; then op=11 start -> done at cycle 1, result=0, Z=1.
- SHL:
  - opa=0x8000_0001, opb=1 -> result=0x0000_0002, C=1, done at cycle 3.
  - opb=0 -> done at cycle 2, result=opa, C=0.
  - opb=40 -> result=0, C=0.
- SHR:
  - opa=0x0000_0003, opb=1 -> result=1, C=1.
  - opb=33 with opa=0xFFFF_FFFF -> result=0, C=0, Z=1, done at cycle 35.
- Flush and ignored start:
  - MUL 5*5, flush at cycle 10 -> no done pulse, outputs keep their previous values, stall_req=0 from cycle 11.
  - start asserted during RUN -> ignored.
  - start+flush in IDLE -> not accepted.
- Async reset: drop reset mid-RUN between clock edges -> busy, stall_req and result go to 0 immediately without waiting for a clock edge; a new MUL 3*3 after release -> result=9.
